prg_loader: RTL and testbench

- Hardware program loader that replaces the soft monitor on the CDECv programmer interface.
- Consumes a byte stream from a UART receiver and executes write, read and dump commands on CDECv program memory.
- Drives prg_clock, prg_we, prg_MA and prg_WD, and samples prg_RD.
- Returns response bytes to a UART transmitter over a valid/ready handshake.

---
 rtl/prg_loader.sv | 191 +++++++++++++++++++
 tb/tb_prg_loader.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/prg_loader.sv
// prg_loader: UART-driven program loader for the CDECv programmer port.
// Decodes W/R/D commands from the rx byte stream, runs timed accesses on
// prg_clock/prg_we/prg_MA/prg_WD and returns response bytes over tx.
module prg_loader #(
  parameter int SETUP_CYCLES   = 2,
  parameter int PULSE_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic       clock,
  input  logic       n_reset,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       prg_clock,
  output logic       prg_we,
  output logic [7:0] prg_MA,
  output logic [7:0] prg_WD,
  input  logic [7:0] prg_RD,
  output logic       busy,
  output logic [1:0] error
);

  localparam int PMAX = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
  localparam int PW   = $clog2(PMAX + 1);
  localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [PW-1:0] SETUP_LAST = PW'(SETUP_CYCLES - 1);
  localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_GET_ADDR, S_GET_DATA, S_GET_COUNT,
    S_SETUP, S_PULSE_HI, S_PULSE_LO, S_SEND
  } state_t;

  typedef enum logic [1:0] {C_W, C_R, C_D, C_BAD} cmd_t;

  state_t        state;
  cmd_t          cmd;
  logic [7:0]    addr;
  logic [8:0]    remain;   // bytes left in a dump, 1..256
  logic [PW-1:0] tmr;      // phase timer for SETUP / PULSE_HI / PULSE_LO
  logic [TW-1:0] to_cnt;   // inter-byte idle counter while collecting a command

  logic in_get, in_acc, to_hit;

  assign in_get = (state == S_GET_ADDR) || (state == S_GET_DATA) || (state == S_GET_COUNT);
  assign in_acc = (state == S_SETUP) || (state == S_PULSE_HI) ||
                  (state == S_PULSE_LO) || (state == S_SEND);
  // Abort happens on the edge where the idle count would reach TIMEOUT_CYCLES
  assign to_hit = !rx_valid && (to_cnt == TO_LAST);
  assign busy   = (state != S_IDLE);

  // Command FSM with registered programmer-port and tx outputs
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state     <= S_IDLE;
      cmd       <= C_W;
      addr      <= '0;
      remain    <= '0;
      tmr       <= '0;
      to_cnt    <= '0;
      tx_data   <= '0;
      tx_valid  <= 1'b0;
      prg_clock <= 1'b0;
      prg_we    <= 1'b0;
      prg_MA    <= '0;
      prg_WD    <= '0;
      error     <= '0;
    end else begin
      to_cnt <= (in_get && !rx_valid && !to_hit) ? to_cnt + 1'b1 : '0;
      // Bytes arriving mid-operation are dropped; the access carries on
      if (rx_valid && in_acc) error[0] <= 1'b1;

      case (state)
        S_IDLE: begin
          if (rx_valid) begin
            case (rx_data)
              8'h57: begin cmd <= C_W; state <= S_GET_ADDR; end
              8'h52: begin cmd <= C_R; state <= S_GET_ADDR; end
              8'h44: begin cmd <= C_D; state <= S_GET_ADDR; end
              default: begin
                cmd      <= C_BAD;
                tx_data  <= 8'h3F;
                tx_valid <= 1'b1;
                state    <= S_SEND;
              end
            endcase
          end
        end

        S_GET_ADDR: begin
          if (rx_valid) begin
            addr <= rx_data;
            case (cmd)
              C_W:     state <= S_GET_DATA;
              C_D:     state <= S_GET_COUNT;
              default: begin
                prg_MA <= rx_data;
                tmr    <= '0;
                state  <= S_SETUP;
              end
            endcase
          end else if (to_hit) begin
            error[1] <= 1'b1;
            state    <= S_IDLE;
          end
        end

        S_GET_DATA: begin
          if (rx_valid) begin
            prg_MA <= addr;
            prg_WD <= rx_data;
            prg_we <= 1'b1;
            tmr    <= '0;
            state  <= S_SETUP;
          end else if (to_hit) begin
            error[1] <= 1'b1;
            state    <= S_IDLE;
          end
        end

        S_GET_COUNT: begin
          if (rx_valid) begin
            remain <= (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
            prg_MA <= addr;
            tmr    <= '0;
            state  <= S_SETUP;
          end else if (to_hit) begin
            error[1] <= 1'b1;
            state    <= S_IDLE;
          end
        end

        S_SETUP: begin
          if (tmr == SETUP_LAST) begin
            tmr       <= '0;
            prg_clock <= 1'b1;
            state     <= S_PULSE_HI;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end

        S_PULSE_HI: begin
          if (tmr == PULSE_LAST) begin
            tmr       <= '0;
            prg_clock <= 1'b0;
            state     <= S_PULSE_LO;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end

        S_PULSE_LO: begin
          if (tmr == PULSE_LAST) begin
            tmr      <= '0;
            prg_we   <= 1'b0;
            tx_data  <= (cmd == C_W) ? 8'h2B : prg_RD;
            tx_valid <= 1'b1;
            state    <= S_SEND;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end

        S_SEND: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            if (cmd == C_D) begin
              remain <= remain - 1'b1;
              addr   <= addr + 8'd1;
            end
            if (cmd == C_D && remain != 9'd1) begin
              prg_MA <= addr + 8'd1;
              tmr    <= '0;
              state  <= S_SETUP;
            end else begin
              state <= S_IDLE;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prg_loader.sv
// tb_prg_loader: directed and randomized checks of prg_loader against a
// command-level reference model (expected response bytes and access list).
module tb_prg_loader;

  localparam int SETUP = 2;
  localparam int PULSE = 4;
  localparam int TMO   = 100;

  logic       clock = 0, n_reset = 0, rx_valid = 0, tx_ready = 0;
  logic [7:0] rx_data = 0;
  logic [7:0] tx_data, prg_MA, prg_WD, prg_RD;
  logic       tx_valid, prg_clock, prg_we, busy;
  logic [1:0] error;

  logic [7:0] mem     [256];   // memory seen by the DUT
  logic [7:0] ref_mem [256];   // model's view of memory

  prg_loader #(.SETUP_CYCLES(SETUP), .PULSE_CYCLES(PULSE), .TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock), .n_reset(n_reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .prg_clock(prg_clock), .prg_we(prg_we), .prg_MA(prg_MA), .prg_WD(prg_WD),
    .prg_RD(prg_RD), .busy(busy), .error(error)
  );

  initial forever #10 clock = ~clock;

  assign prg_RD = mem[prg_MA];

  int n_cmp = 0, n_fail = 0;
  logic [7:0] rsp_q[$], acc_ma[$], acc_wd[$], exp_rsp[$], exp_ma[$], exp_wd[$], cmd_q[$];
  logic       acc_we[$], exp_we[$];
  int         pulse_q[$], we_q[$];
  int         hi_run = 0, we_run = 0, we_bad = 0;
  int         tx_wait = 0, tx_stall = 0, tx_unstable = 0;
  logic [7:0] tx_first, we_ma0, we_wd0;

  // Memory side: capture each access and perform writes
  initial forever begin
    @(posedge prg_clock);
    acc_ma.push_back(prg_MA);
    acc_we.push_back(prg_we);
    acc_wd.push_back(prg_WD);
    if (prg_we) mem[prg_MA] = prg_WD;
  end

  // Pulse width, write-enable length and address/data hold while writing
  initial forever begin
    @(negedge clock);
    if (prg_clock) hi_run++;
    else if (hi_run != 0) begin pulse_q.push_back(hi_run); hi_run = 0; end
    if (prg_we) begin
      if (we_run == 0) begin we_ma0 = prg_MA; we_wd0 = prg_WD; end
      else if (prg_MA !== we_ma0 || prg_WD !== we_wd0) we_bad++;
      we_run++;
    end else if (we_run != 0) begin
      we_q.push_back(we_run); we_run = 0;
    end
  end

  // Transmit sink: holds off tx_ready for tx_stall clocks per byte
  initial forever begin
    @(negedge clock);
    if (n_reset && tx_valid) begin
      if (tx_wait == 0) tx_first = tx_data;
      else if (tx_data !== tx_first) tx_unstable++;
      if (tx_wait >= tx_stall) begin
        tx_ready = 1; rsp_q.push_back(tx_data); tx_wait = 0;
      end else begin
        tx_ready = 0; tx_wait++;
      end
    end else begin
      tx_ready = 0; tx_wait = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_obs();
    rsp_q.delete(); acc_ma.delete(); acc_we.delete(); acc_wd.delete();
    pulse_q.delete(); we_q.delete();
    exp_rsp.delete(); exp_ma.delete(); exp_we.delete(); exp_wd.delete();
    we_bad = 0; tx_unstable = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge clock); rx_valid = 1; rx_data = b;
    @(negedge clock); rx_valid = 0;
    repeat (gap) @(negedge clock);
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin @(negedge clock); #1; n++; end while (busy && n < 8000);
    repeat (2) @(negedge clock);
  endtask

  task automatic init_mem(input int mode);
    for (int i = 0; i < 256; i++) begin
      mem[i] = (mode == 0) ? (8'(i) ^ 8'hFF) : 8'($urandom);
      ref_mem[i] = mem[i];
    end
  endtask

  // Reference model: what a whole command must produce
  task automatic model_cmd();
    logic [7:0] a;
    int n;
    case (cmd_q[0])
      8'h57: begin
        exp_ma.push_back(cmd_q[1]); exp_we.push_back(1); exp_wd.push_back(cmd_q[2]);
        ref_mem[cmd_q[1]] = cmd_q[2];
        exp_rsp.push_back(8'h2B);
      end
      8'h52: begin
        exp_ma.push_back(cmd_q[1]); exp_we.push_back(0); exp_wd.push_back(0);
        exp_rsp.push_back(ref_mem[cmd_q[1]]);
      end
      8'h44: begin
        n = (cmd_q[2] == 0) ? 256 : int'(cmd_q[2]);
        a = cmd_q[1];
        for (int i = 0; i < n; i++) begin
          exp_ma.push_back(a); exp_we.push_back(0); exp_wd.push_back(0);
          exp_rsp.push_back(ref_mem[a]);
          a = a + 8'd1;
        end
      end
      default: exp_rsp.push_back(8'h3F);
    endcase
  endtask

  task automatic compare();
    int bad, nw;
    chk("rsp_count", rsp_q.size(), exp_rsp.size());
    for (int i = 0; i < rsp_q.size() && i < exp_rsp.size(); i++)
      chk("rsp_byte", rsp_q[i], exp_rsp[i]);
    chk("acc_count", acc_ma.size(), exp_ma.size());
    for (int i = 0; i < acc_ma.size() && i < exp_ma.size(); i++) begin
      chk("acc_ma", acc_ma[i], exp_ma[i]);
      chk("acc_we", acc_we[i], exp_we[i]);
      if (exp_we[i]) chk("acc_wd", acc_wd[i], exp_wd[i]);
    end
    bad = 0;
    foreach (pulse_q[i]) if (pulse_q[i] != PULSE) bad++;
    chk("pulse_count", pulse_q.size(), exp_ma.size());
    chk("pulse_width_bad", bad, 0);
    nw = 0; bad = 0;
    foreach (exp_we[i]) if (exp_we[i]) nw++;
    foreach (we_q[i]) if (we_q[i] != SETUP + 2 * PULSE) bad++;
    chk("we_count", we_q.size(), nw);
    chk("we_len_bad", bad, 0);
    chk("we_hold_bad", we_bad, 0);
    chk("tx_stable_bad", tx_unstable, 0);
    chk("busy_end", busy, 0);
  endtask

  task automatic run_cmd(input int gap);
    clear_obs();
    model_cmd();
    foreach (cmd_q[i]) send_byte(cmd_q[i], gap);
    wait_idle();
    compare();
  endtask

  initial begin
    int lat;
    init_mem(0);
    #35 n_reset = 1;
    @(negedge clock);
    chk("reset_outputs", {tx_valid, prg_clock, prg_we, busy, error, tx_data, prg_MA, prg_WD}, 0);

    // Single write
    tx_stall = 0;
    cmd_q = '{8'h57, 8'h10, 8'hA5}; run_cmd(0);
    chk("w_mem", mem[8'h10], 8'hA5);
    chk("idle_hold_ma", prg_MA, 8'h10);
    chk("idle_hold_wd", prg_WD, 8'hA5);

    // Read with exact latency from the address strobe
    mem[8'h20] = 8'h3C; ref_mem[8'h20] = 8'h3C;
    cmd_q = '{8'h52, 8'h20};
    clear_obs(); model_cmd();
    send_byte(8'h52, 0);
    rx_valid = 1; rx_data = 8'h20;
    lat = 0;
    do begin
      @(posedge clock); #1; lat++;
      if (lat == 1) rx_valid = 0;
    end while (!tx_valid && lat < 40);
    chk("r_latency", lat, 1 + SETUP + 2 * PULSE);
    chk("r_tx_data", tx_data, 8'h3C);
    wait_idle(); compare();

    // Dump across the address wrap with a stalled transmitter
    init_mem(0); tx_stall = 5;
    cmd_q = '{8'h44, 8'hFE, 8'h03}; run_cmd(0);

    // Count 0 means a full 256-byte dump
    tx_stall = 0;
    cmd_q = '{8'h44, 8'h00, 8'h00}; run_cmd(1);

    // Unknown command
    cmd_q = '{8'h41}; run_cmd(0);
    chk("err_before_timeout", error, 2'b00);

    // Inter-byte timeout after 'W' addr
    clear_obs();
    send_byte(8'h57, 0);
    rx_valid = 1; rx_data = 8'h05;
    @(posedge clock); #1 rx_valid = 0;
    repeat (TMO - 1) @(posedge clock);
    #1 chk("to_busy_before", busy, 1);
    @(posedge clock);
    #1 chk("to_busy_after", busy, 0);
    repeat (3) @(negedge clock);
    chk("to_error", error, 2'b10);
    chk("to_no_tx", rsp_q.size(), 0);
    chk("to_no_access", acc_ma.size(), 0);
    chk("to_no_we", we_q.size(), 0);

    // Overrun during PULSE_HI of a write
    cmd_q = '{8'h57, 8'h30, 8'h5A};
    clear_obs(); model_cmd();
    foreach (cmd_q[i]) send_byte(cmd_q[i], 0);
    repeat (2) @(negedge clock);
    chk("ovr_in_pulse", prg_clock, 1);
    rx_valid = 1; rx_data = 8'h52;
    @(negedge clock); rx_valid = 0;
    wait_idle(); compare();
    chk("ovr_mem", mem[8'h30], 8'h5A);
    chk("ovr_error0", error[0], 1);

    // Asynchronous reset in the middle of a write pulse
    cmd_q = '{8'h57, 8'h40, 8'h77};
    foreach (cmd_q[i]) send_byte(cmd_q[i], 0);
    repeat (2) @(negedge clock);
    chk("rst_in_pulse", prg_clock, 1);
    #2 n_reset = 0;
    #1 chk("rst_async", {prg_clock, prg_we, busy, error}, 0);
    @(negedge clock); n_reset = 1;
    repeat (2) @(negedge clock);

    // Randomized command stream
    init_mem(1);
    for (int t = 0; t < 40; t++) begin
      logic [7:0] b;
      tx_stall = $urandom_range(0, 3);
      cmd_q.delete();
      case ($urandom_range(0, 3))
        0: cmd_q = '{8'h57, 8'($urandom), 8'($urandom)};
        1: cmd_q = '{8'h52, 8'($urandom)};
        2: cmd_q = '{8'h44, 8'($urandom), 8'($urandom_range(1, 6))};
        default: begin
          do b = 8'($urandom); while (b == 8'h57 || b == 8'h52 || b == 8'h44);
          cmd_q = '{b};
        end
      endcase
      run_cmd($urandom_range(0, 4));
    end
    chk("rand_no_timeout", error[1], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
